alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
- Fetch/decode/control sequencer that drives the 64-bit ALU's control inputs.
- Fetches 64-bit instruction words from instruction memory and decodes them into the ALU's `instr`, `value` and `highlow` inputs, plus register-file read and write selects.
- Consumes the ALU's flag output `F3` and its branch outputs `addrch` and `naddr`.
- Keeps the program counter and the two-entry flag history that feeds back to the ALU's `F1` and `F2` inputs.

Parameters:
- ADDR_W, 32, program counter and instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- REG_W, 4, register index width (16 registers).

Ports:
- clock  in  1  system clock, all state updates on its rising edge.
- resetn  in  1  synchronous, active-low reset.
- imem_req  out  1  fetch request, held high until `imem_ack`.
- imem_addr  out  ADDR_W  fetch address, equal to the PC while `imem_req` is high.
- imem_ack  in  1  fetch data valid this cycle.
- imem_rdata  in  64  instruction word.
- alu_instr  out  6  ALU opcode.
- alu_value  out  32  immediate for load-half (op 5).
- alu_highlow  out  1  load-half select.
- alu_f1  out  1  flag F1 to the ALU.
- alu_f2  out  1  flag F2 to the ALU.
- alu_f3  in  1  ALU flag result.
- alu_addrch  in  1  ALU branch-taken.
- alu_naddr  in  64  ALU branch target.
- alu_c  in  64  ALU result.
- rf_raddr_a  out  REG_W  source A select.
- rf_raddr_b  out  REG_W  source B select.
- rf_we  out  1  register write enable (1-cycle pulse).
- rf_waddr  out  REG_W  destination register.
- rf_wdata  out  64  write data.
- halted  out  1  sequencer stopped.
- illegal  out  1  1-cycle pulse on an undefined opcode.
- restart  in  1  leave HALT and resume at the current PC.

Behaviour:

Instruction word fields:
- [5:0] opcode
- [9:6] rd
- [13:10] rs_a
- [17:14] rs_b
- [18] highlow
- [31:19] reserved, ignored
- [63:32] imm

Reset (`resetn` low at a clock edge):
- State goes to FETCH and PC = RESET_PC.
- Flags F1 = F2 = 0.
- `halted`, `illegal`, `rf_we` and `imem_req` are all 0.
- `alu_instr` = 6'd18 (NOP code). `alu_value`, `alu_highlow`, `rf_*addr` and `rf_wdata` are 0.
- Reset mid-fetch drops `imem_req` immediately; a late `imem_ack` is ignored.

FSM states are FETCH, EXEC and HALT.
- FETCH:
  - `imem_req` = 1 and `imem_addr` = PC.
  - On `imem_ack`, capture `imem_rdata` into the instruction register and go to EXEC.
  - `imem_req` goes low on the cycle after ack.
  - `alu_instr` = 18 throughout FETCH.
- EXEC (exactly 1 cycle):
  - Drive `alu_instr` = opcode, `alu_value` = imm, `alu_highlow` = bit 18, and `rf_raddr_a`/`rf_raddr_b` from the instruction register.
  - The ALU is combinational; its outputs are sampled at the end of EXEC.
  - Next state is FETCH, or HALT for opcode 63.
- HALT:
  - `halted` = 1 and `alu_instr` = 18.
  - `restart` high moves the FSM to FETCH. The PC is already advanced past the halt.

Effects sampled at the end of EXEC, per opcode:
- Ops 0, 1, 2, 3, 4, 5, 16 and 17:
  - `rf_we` pulses for the next cycle, with `rf_waddr` = rd and `rf_wdata` = `alu_c` registered.
  - The write lands in the first FETCH cycle.
- Ops 6 and 7: no register write and no PC redirect.
- Ops 8–13: F2 <= F1 and F1 <= `alu_f3`.
- Ops 14 and 15: no flag update.
- PC update:
  - If `alu_addrch` = 1, PC <= `alu_naddr`[ADDR_W-1:0].
  - Otherwise PC <= PC+1.
  - The PC wraps modulo 2^ADDR_W.
- Ops 18–62:
  - Treated as NOP: no write, no flag change, PC+1.
  - `illegal` pulses 1 cycle.
- Op 63: PC+1, then HALT.

Timing and boundary cases:
- `alu_f1` and `alu_f2` are direct register outputs and stay stable through EXEC.
- Minimum throughput is 1 instruction per 2 cycles (ack in the first FETCH cycle).
- Each extra cycle without ack adds one cycle of latency.
- `restart` asserted outside HALT is ignored.
- `imem_ack` outside FETCH is ignored.
- Back-to-back branch-to-self: the PC stays constant and the loop is legal.

Decomposition:
- Shared package `alu_pkg` holds:
  - opcode localparams (OP_ADD=0, OP_SUB=1, OP_SHL=2, OP_SHR=3, OP_MOV=4, OP_LDH=5, OP_ADR6=6, OP_ADR7=7, OP_EQ=8, OP_LT=9, OP_GT=10, OP_NOT=11, OP_AND=12, OP_FLG=13, OP_JMP=14, OP_JC=15, OP_DIV=16, OP_MUL=17, OP_NOP=18, OP_HALT=63)
  - instruction field bit positions
  - the FSM state enum
- One sub-module, `instr_decode`:
  - Combinational, from opcode to {writes_rf, writes_flags, is_halt, is_illegal}.
  - Shared with future pipeline work.

Test Plan:
- Reset, then ack after 2 wait cycles with word op 0 (rd=3, rs_a=1, rs_b=2) and `alu_c` = 0x5 → `imem_addr` = 0. `alu_instr` = 0 for exactly 1 cycle. `rf_we` pulses with `rf_waddr` = 3 and `rf_wdata` = 0x5. Next `imem_addr` = 1.
- Op 8 with `alu_f3` = 1, then op 9 with `alu_f3` = 0 → after the first, F1=1 and F2=0. After the second, F1=0 and F2=1. No `rf_we` on either.
- Op 15 with `alu_addrch` = 1 and `alu_naddr` = 0x40 → next `imem_addr` = 0x40. With `alu_addrch` = 0 → PC+1.
- PC = 2^ADDR_W−1 executing op 0 → next `imem_addr` = 0 (wrap).
- Op 40 → `illegal` pulses once, no write, flags unchanged, PC+1. Then op 63 → `halted` = 1 and no `imem_req`. `restart` → fetch resumes at the halt PC+1.
- `resetn` low during a FETCH wait, with ack arriving in the reset cycle → ack ignored. After reset, `imem_req` = 1 and `imem_addr` = RESET_PC. F1 = F2 = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU sequencer: opcodes, instruction field
// positions and the sequencer state encoding.
package alu_pkg;

    localparam logic [5:0] OP_ADD  = 6'd0;
    localparam logic [5:0] OP_SUB  = 6'd1;
    localparam logic [5:0] OP_SHL  = 6'd2;
    localparam logic [5:0] OP_SHR  = 6'd3;
    localparam logic [5:0] OP_MOV  = 6'd4;
    localparam logic [5:0] OP_LDH  = 6'd5;
    localparam logic [5:0] OP_ADR6 = 6'd6;
    localparam logic [5:0] OP_ADR7 = 6'd7;
    localparam logic [5:0] OP_EQ   = 6'd8;
    localparam logic [5:0] OP_LT   = 6'd9;
    localparam logic [5:0] OP_GT   = 6'd10;
    localparam logic [5:0] OP_NOT  = 6'd11;
    localparam logic [5:0] OP_AND  = 6'd12;
    localparam logic [5:0] OP_FLG  = 6'd13;
    localparam logic [5:0] OP_JMP  = 6'd14;
    localparam logic [5:0] OP_JC   = 6'd15;
    localparam logic [5:0] OP_DIV  = 6'd16;
    localparam logic [5:0] OP_MUL  = 6'd17;
    localparam logic [5:0] OP_NOP  = 6'd18;
    localparam logic [5:0] OP_HALT = 6'd63;

    // Instruction word layout (bits 31:19 are reserved)
    localparam int F_OP_LSB  = 0;
    localparam int F_RD_LSB  = 6;
    localparam int F_RSA_LSB = 10;
    localparam int F_RSB_LSB = 14;
    localparam int F_HL_BIT  = 18;
    localparam int F_IMM_LSB = 32;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_HALT  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_sequencer_decode.sv
// Opcode classifier: maps a 6-bit opcode to the side effects the
// sequencer applies at the end of EXEC.
module instr_decode
    import alu_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_writes_rf,
    output logic       o_writes_flags,
    output logic       o_is_halt,
    output logic       o_is_illegal
);

    assign o_writes_rf    = (i_opcode <= OP_LDH) || (i_opcode == OP_DIV) || (i_opcode == OP_MUL);
    assign o_writes_flags = (i_opcode >= OP_EQ) && (i_opcode <= OP_FLG);
    assign o_is_halt      = (i_opcode == OP_HALT);
    // Everything from the NOP code up to (not including) HALT is undefined
    assign o_is_illegal   = (i_opcode >= OP_NOP) && (i_opcode != OP_HALT);

endmodule

// File: rtl/alu_sequencer.sv
// Fetch/decode/control sequencer for the 64-bit ALU. Fetches one
// instruction word, drives the ALU for exactly one EXEC cycle, then
// commits register write, flag history and PC from the ALU outputs.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                REG_W    = 4
) (
    input  logic              clock,
    input  logic              resetn,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [63:0]       imem_rdata,
    output logic [5:0]        alu_instr,
    output logic [31:0]       alu_value,
    output logic              alu_highlow,
    output logic              alu_f1,
    output logic              alu_f2,
    input  logic              alu_f3,
    input  logic              alu_addrch,
    input  logic [63:0]       alu_naddr,
    input  logic [63:0]       alu_c,
    output logic [REG_W-1:0]  rf_raddr_a,
    output logic [REG_W-1:0]  rf_raddr_b,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [63:0]       rf_wdata,
    output logic              halted,
    output logic              illegal,
    input  logic              restart
);

    seq_state_e        r_state;
    logic [ADDR_W-1:0] r_pc;
    logic              r_f1;
    logic              r_f2;
    logic [5:0]        r_op;
    logic [REG_W-1:0]  r_rd;
    logic [REG_W-1:0]  r_rsa;
    logic [REG_W-1:0]  r_rsb;
    logic              r_hl;
    logic [31:0]       r_imm;
    logic              r_we;
    logic [REG_W-1:0]  r_waddr;
    logic [63:0]       r_wdata;
    logic              r_illegal;

    logic              w_writes_rf;
    logic              w_writes_flags;
    logic              w_is_halt;
    logic              w_is_illegal;
    logic              w_redirect_ok;
    logic              w_unused_bits;

    instr_decode u_decode (
        .i_opcode       (r_op),
        .o_writes_rf    (w_writes_rf),
        .o_writes_flags (w_writes_flags),
        .o_is_halt      (w_is_halt),
        .o_is_illegal   (w_is_illegal)
    );

    // Reserved instruction bits and upper branch-target bits carry no meaning here
    assign w_unused_bits = ^{imem_rdata[31:19], alu_naddr[63:ADDR_W]};

    // The ALU may only redirect the PC for defined, non-address, non-halt ops
    assign w_redirect_ok = (r_op != OP_ADR6) && (r_op != OP_ADR7) && !w_is_illegal && !w_is_halt;

    // State, PC, flag history, instruction register and write-back registers
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state   <= S_FETCH;
            r_pc      <= RESET_PC;
            r_f1      <= 1'b0;
            r_f2      <= 1'b0;
            r_op      <= OP_NOP;
            r_rd      <= '0;
            r_rsa     <= '0;
            r_rsb     <= '0;
            r_hl      <= 1'b0;
            r_imm     <= '0;
            r_we      <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_illegal <= 1'b0;
        end else begin
            r_we      <= 1'b0;
            r_illegal <= 1'b0;
            case (r_state)
                S_FETCH: begin
                    if (imem_ack) begin
                        r_op    <= imem_rdata[F_OP_LSB +: 6];
                        r_rd    <= imem_rdata[F_RD_LSB +: REG_W];
                        r_rsa   <= imem_rdata[F_RSA_LSB +: REG_W];
                        r_rsb   <= imem_rdata[F_RSB_LSB +: REG_W];
                        r_hl    <= imem_rdata[F_HL_BIT];
                        r_imm   <= imem_rdata[F_IMM_LSB +: 32];
                        r_state <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (w_writes_rf) begin
                        r_we    <= 1'b1;
                        r_waddr <= r_rd;
                        r_wdata <= alu_c;
                    end
                    if (w_writes_flags) begin
                        r_f2 <= r_f1;
                        r_f1 <= alu_f3;
                    end
                    r_illegal <= w_is_illegal;
                    if (w_redirect_ok && alu_addrch)
                        r_pc <= alu_naddr[ADDR_W-1:0];
                    else
                        r_pc <= r_pc + ADDR_W'(1);
                    r_state <= w_is_halt ? S_HALT : S_FETCH;
                end
                S_HALT: begin
                    if (restart)
                        r_state <= S_FETCH;
                end
                default: r_state <= S_FETCH;
            endcase
        end
    end

    // Request is gated by reset so an in-progress fetch drops in the reset cycle
    assign imem_req    = resetn && (r_state == S_FETCH);
    assign imem_addr   = r_pc;
    assign alu_instr   = (r_state == S_EXEC) ? r_op : OP_NOP;
    assign alu_value   = r_imm;
    assign alu_highlow = r_hl;
    assign alu_f1      = r_f1;
    assign alu_f2      = r_f2;
    assign rf_raddr_a  = r_rsa;
    assign rf_raddr_b  = r_rsb;
    assign rf_we       = r_we;
    assign rf_waddr    = r_waddr;
    assign rf_wdata    = r_wdata;
    assign halted      = (r_state == S_HALT);
    assign illegal     = r_illegal;

endmodule
